// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and small helpers shared by the VGA
// timing generator and its per-axis counters.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_CNT_W    = 10;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decode taken
// from the next-state count so the registered sync lines up with the count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = DEF_HS_POL,
    parameter int W      = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         terminal,
    output logic         sync,
    output logic         active_next
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         sync_reg;
    logic         sync_next;

    always_comb begin
        count_next = count_reg;
        if (advance) begin
            count_next = (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
        sync_next   = ((count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST)) ? POL : ~POL;
        active_next = (count_next < ACTIVE_END);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
            sync_reg  <= ~POL;
        end else begin
            count_reg <= count_next;
            sync_reg  <= sync_next;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == LAST);
    assign sync     = sync_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock prescaler, horizontal and vertical
// axis counters, registered sync/blank outputs and line/frame strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             pix_tick,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int PRE_W   = cnt_width(CLK_DIV);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CNT_W < 1 ||
        (longint'(1) << CNT_W) < longint'(H_TOTAL) ||
        (longint'(1) << CNT_W) < longint'(V_TOTAL)) begin : g_bad_params
        $error("vga_timing_gen: illegal parameter set");
    end

    logic [PRE_W-1:0] prescaler_reg;
    logic [PRE_W-1:0] prescaler_next;
    logic             video_on_reg;
    logic             h_terminal;
    logic             v_terminal;
    logic             h_active_next;
    logic             v_active_next;
    logic             v_advance;

    always_comb begin
        prescaler_next = prescaler_reg;
        if (Enable) begin
            prescaler_next = (prescaler_reg == PRE_LAST) ? '0 : prescaler_reg + 1'b1;
        end
    end

    // video_on is refreshed every cycle from the next-state counters; while
    // frozen those equal the current counters, so the flag simply holds.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prescaler_reg <= '0;
            video_on_reg  <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_next;
            video_on_reg  <= h_active_next && v_active_next;
        end
    end

    assign pix_tick  = Enable && (prescaler_reg == PRE_LAST);
    assign line_end  = pix_tick && h_terminal;
    assign frame_end = line_end && v_terminal;
    assign v_advance = line_end;
    assign video_on  = video_on_reg;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL),
        .W      (CNT_W)
    ) u_h_axis (
        .clk         (Clk),
        .srst        (Reset),
        .advance     (pix_tick),
        .count       (hcount),
        .terminal    (h_terminal),
        .sync        (hsync),
        .active_next (h_active_next)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL),
        .W      (CNT_W)
    ) u_v_axis (
        .clk         (Clk),
        .srst        (Reset),
        .advance     (v_advance),
        .count       (vcount),
        .terminal    (v_terminal),
        .sync        (vsync),
        .active_next (v_active_next)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: two reduced-geometry instances (divide-by-2
// active-low, divide-by-1 active-high) plus one default 640x480 instance.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hfp; int hsw; int hbp;
        int va; int vfp; int vsw; int vbp;
        int div;
        bit hp; bit vp;
    } geo_t;

    typedef struct packed {
        int pre; int h; int v;
        bit rst_seen;
    } mdl_t;

    localparam geo_t GEO_A = '{ha:8, hfp:2, hsw:3, hbp:3, va:4, vfp:1, vsw:2, vbp:1,
                               div:2, hp:1'b0, vp:1'b0};
    localparam geo_t GEO_B = '{ha:8, hfp:2, hsw:3, hbp:3, va:4, vfp:1, vsw:2, vbp:1,
                               div:1, hp:1'b1, vp:1'b1};
    localparam geo_t GEO_D = '{ha:640, hfp:16, hsw:96, hbp:48, va:480, vfp:10, vsw:2, vbp:33,
                               div:2, hp:1'b0, vp:1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, rst_b, en_b, rst_d, en_d;
    logic [3:0] hc_a, vc_a, hc_b, vc_b;
    logic [9:0] hc_d, vc_d;
    logic       hs_a, vs_a, vo_a, pt_a, le_a, fe_a;
    logic       hs_b, vs_b, vo_b, pt_b, le_b, fe_b;
    logic       hs_d, vs_d, vo_d, pt_d, le_d, fe_d;

    int n_tests = 0;
    int n_fail  = 0;
    mdl_t ma = '0, mb = '0, md = '0;
    int pt_cnt_a, fe_cnt_a, fe_cnt_b, hs_hi_b, vs_hi_b, hs_lo_d, vo_hi_d;

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4)
    ) dut_a (
        .Clk(clk), .Reset(rst_a), .Enable(en_a), .hcount(hc_a), .vcount(vc_a),
        .hsync(hs_a), .vsync(vs_a), .video_on(vo_a), .pix_tick(pt_a),
        .line_end(le_a), .frame_end(fe_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .Clk(clk), .Reset(rst_b), .Enable(en_b), .hcount(hc_b), .vcount(vc_b),
        .hsync(hs_b), .vsync(vs_b), .video_on(vo_b), .pix_tick(pt_b),
        .line_end(le_b), .frame_end(fe_b)
    );

    vga_timing_gen dut_d (
        .Clk(clk), .Reset(rst_d), .Enable(en_d), .hcount(hc_d), .vcount(vc_d),
        .hsync(hs_d), .vsync(vs_d), .video_on(vo_d), .pix_tick(pt_d),
        .line_end(le_d), .frame_end(fe_d)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Reference raster position after one clock edge.
    task automatic adv(input mdl_t mi, input geo_t g, input logic rst, input logic en,
                       output mdl_t mo);
        int htot, vtot;
        htot = g.ha + g.hfp + g.hsw + g.hbp;
        vtot = g.va + g.vfp + g.vsw + g.vbp;
        mo = mi;
        if (rst) begin
            mo.pre = 0; mo.h = 0; mo.v = 0; mo.rst_seen = 1'b1;
        end else begin
            mo.rst_seen = 1'b0;
            if (en) begin
                if (mi.pre == g.div - 1) begin
                    mo.pre = 0;
                    if (mi.h == htot - 1) begin
                        mo.h = 0;
                        mo.v = (mi.v == vtot - 1) ? 0 : mi.v + 1;
                    end else begin
                        mo.h = mi.h + 1;
                    end
                end else begin
                    mo.pre = mi.pre + 1;
                end
            end
        end
    endtask

    task automatic check_dut(input string nm, input geo_t g, input mdl_t m, input logic en,
                             input logic [15:0] hc, input logic [15:0] vc,
                             input logic hs, input logic vs, input logic vo,
                             input logic pt, input logic le, input logic fe);
        int htot, vtot;
        logic e_pt, e_le, e_fe, e_hs, e_vs, e_vo;
        htot = g.ha + g.hfp + g.hsw + g.hbp;
        vtot = g.va + g.vfp + g.vsw + g.vbp;
        e_pt = en && (m.pre == g.div - 1);
        e_le = e_pt && (m.h == htot - 1);
        e_fe = e_le && (m.v == vtot - 1);
        e_hs = (m.h >= g.ha + g.hfp && m.h < g.ha + g.hfp + g.hsw) ? g.hp : ~g.hp;
        e_vs = (m.v >= g.va + g.vfp && m.v < g.va + g.vfp + g.vsw) ? g.vp : ~g.vp;
        e_vo = m.rst_seen ? 1'b0 : (m.h < g.ha && m.v < g.va);
        chk({nm, ".hcount"}, hc, 16'(m.h));
        chk({nm, ".vcount"}, vc, 16'(m.v));
        chk1({nm, ".hsync"}, hs, e_hs);
        chk1({nm, ".vsync"}, vs, e_vs);
        chk1({nm, ".video_on"}, vo, e_vo);
        chk1({nm, ".pix_tick"}, pt, e_pt);
        chk1({nm, ".line_end"}, le, e_le);
        chk1({nm, ".frame_end"}, fe, e_fe);
    endtask

    task automatic tick_all();
        mdl_t na, nb, nd;
        adv(ma, GEO_A, rst_a, en_a, na);
        adv(mb, GEO_B, rst_b, en_b, nb);
        adv(md, GEO_D, rst_d, en_d, nd);
        @(posedge clk);
        #1;
        ma = na; mb = nb; md = nd;
        check_dut("A", GEO_A, ma, en_a, {12'b0, hc_a}, {12'b0, vc_a}, hs_a, vs_a, vo_a, pt_a, le_a, fe_a);
        check_dut("B", GEO_B, mb, en_b, {12'b0, hc_b}, {12'b0, vc_b}, hs_b, vs_b, vo_b, pt_b, le_b, fe_b);
        check_dut("D", GEO_D, md, en_d, {6'b0, hc_d}, {6'b0, vc_d}, hs_d, vs_d, vo_d, pt_d, le_d, fe_d);
        if (pt_a === 1'b1) pt_cnt_a++;
        if (fe_a === 1'b1) fe_cnt_a++;
        if (fe_b === 1'b1) fe_cnt_b++;
        if (hs_b === 1'b1) hs_hi_b++;
        if (vs_b === 1'b1) vs_hi_b++;
        if (hs_d === 1'b0) hs_lo_d++;
        if (vo_d === 1'b1) vo_hi_d++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic reached;
        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;
        rst_d = 1'b1; en_d = 1'b1;

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) tick_all();
        chk("A.rst_hcount", {12'b0, hc_a}, 16'd0);
        chk1("A.rst_hsync", hs_a, 1'b1);
        chk1("A.rst_vsync", vs_a, 1'b1);
        chk1("A.rst_video_on", vo_a, 1'b0);
        chk1("B.rst_hsync", hs_b, 1'b0);
        chk1("B.rst_pix_tick", pt_b, 1'b1);

        // Two reduced frames on A (256 Clk each), four on B (128 Clk each).
        rst_a = 1'b0; rst_b = 1'b0;
        pt_cnt_a = 0; fe_cnt_a = 0; fe_cnt_b = 0; hs_hi_b = 0; vs_hi_b = 0;
        tick_all();
        chk1("A.first_video_on", vo_a, 1'b1);
        for (int i = 1; i < 512; i++) tick_all();
        chk("A.pix_tick_count", 16'(pt_cnt_a), 16'd256);
        chk("A.frame_end_count", 16'(fe_cnt_a), 16'd2);
        chk("B.frame_end_count", 16'(fe_cnt_b), 16'd4);
        chk("B.hsync_high_clks", 16'(hs_hi_b), 16'd96);
        chk("B.vsync_high_clks", 16'(vs_hi_b), 16'd128);

        // Freeze A at hcount=5 for 37 Clk, then resume.
        reached = 1'b0;
        for (int i = 0; i < 600 && !reached; i++) begin
            tick_all();
            reached = (hc_a == 4'd5) && (pt_a == 1'b0);
        end
        chk1("A.reach_h5", reached, 1'b1);
        en_a = 1'b0;
        for (int i = 0; i < 37; i++) begin
            tick_all();
            chk("A.frozen_hcount", {12'b0, hc_a}, 16'd5);
        end
        en_a = 1'b1;
        tick_all();
        chk1("A.resume_pix_tick", pt_a, 1'b1);
        tick_all();
        chk("A.resume_hcount", {12'b0, hc_a}, 16'd6);

        // Reset in the middle of a line inside hsync.
        reached = 1'b0;
        for (int i = 0; i < 600 && !reached; i++) begin
            tick_all();
            reached = (hc_a == 4'd11) && (vc_a == 4'd2);
        end
        chk1("A.reach_h11_v2", reached, 1'b1);
        rst_a = 1'b1;
        tick_all();
        chk("A.midrst_hcount", {12'b0, hc_a}, 16'd0);
        chk("A.midrst_vcount", {12'b0, vc_a}, 16'd0);
        chk1("A.midrst_hsync", hs_a, 1'b1);
        chk1("A.midrst_vsync", vs_a, 1'b1);
        chk1("A.midrst_video_on", vo_a, 1'b0);
        rst_a = 1'b0;
        tick_all();
        chk1("A.postrst_video_on", vo_a, 1'b1);

        // One full default 800-pixel line on D.
        rst_d = 1'b0;
        hs_lo_d = 0; vo_hi_d = 0;
        for (int i = 0; i < 1600; i++) tick_all();
        chk("D.hsync_low_clks", 16'(hs_lo_d), 16'd192);
        chk("D.video_on_clks", 16'(vo_hi_d), 16'd1280);
        chk("D.line1_hcount", {6'b0, hc_d}, 16'd0);
        chk("D.line1_vcount", {6'b0, vc_d}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
